// File: rtl/usbf_wb_mem_req.sv
// Host-side requester in front of the SSRAM arbiter WISHBONE port: queues read/write
// commands, holds wreq until wack, returns in-order completions and flags IDMA starvation.
module usbf_wb_mem_req #(
    parameter int SSRAM_HADR = 14,
    parameter int FIFO_AW    = 1,
    parameter int TMO_CYC    = 255
) (
    input  logic                  phy_clk,
    input  logic                  rst,
    input  logic                  i_cmd_valid,
    output logic                  o_cmd_ready,
    input  logic                  i_cmd_we,
    input  logic [SSRAM_HADR:0]   i_cmd_adr,
    input  logic [31:0]           i_cmd_dat,
    output logic                  o_rsp_valid,
    output logic                  o_rsp_we,
    output logic [31:0]           o_rsp_dat,
    output logic [SSRAM_HADR:0]   o_mem_adr,
    output logic [31:0]           o_mem_dout,
    input  logic [31:0]           i_mem_din,
    output logic                  o_mem_we,
    output logic                  o_mem_req,
    input  logic                  i_mem_ack,
    output logic                  o_starve,
    input  logic                  i_starve_clr,
    output logic                  o_busy,
    output logic                  o_dbg_state
);

    localparam int DEPTH = 1 << FIFO_AW;
    localparam int ADR_W = SSRAM_HADR + 1;
    localparam int EW    = 1 + ADR_W + 32;

    typedef enum logic {S_IDLE = 1'b0, S_REQ = 1'b1} state_t;

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic [EW-1:0]           r_mem [DEPTH];
    logic [FIFO_AW:0]        r_wr_ptr;
    logic [FIFO_AW:0]        r_rd_ptr;
    logic [7:0]              r_stall_cnt;
    logic                    r_starve;
    logic                    r_rsp_valid;
    logic                    r_rsp_we;
    logic [31:0]             r_rsp_dat;

    logic                    w_empty;
    logic                    w_full;
    logic                    w_push;
    logic                    w_pop;
    logic [FIFO_AW:0]        w_count;
    logic [FIFO_AW:0]        w_count_nxt;
    logic [EW-1:0]           w_head;
    logic [8:0]              w_cnt_inc;
    logic                    w_starve_set;

    // Command handshake: a command transfers on a rising edge where i_cmd_valid and
    // o_cmd_ready are both high; o_cmd_ready depends only on FIFO fullness, never on valid.
    assign w_empty     = (r_wr_ptr == r_rd_ptr);
    assign w_full      = (r_wr_ptr[FIFO_AW] != r_rd_ptr[FIFO_AW]) &&
                         (r_wr_ptr[FIFO_AW-1:0] == r_rd_ptr[FIFO_AW-1:0]);
    assign w_push      = i_cmd_valid & ~w_full;
    assign w_pop       = (r_state == S_REQ) & i_mem_ack;
    assign w_count     = r_wr_ptr - r_rd_ptr;
    assign w_count_nxt = w_count + {{FIFO_AW{1'b0}}, w_push} - {{FIFO_AW{1'b0}}, w_pop};
    assign w_head      = r_mem[r_rd_ptr[FIFO_AW-1:0]];

    always_ff @(posedge phy_clk or negedge rst) begin
        if (!rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr[FIFO_AW-1:0]] <= {i_cmd_we, i_cmd_adr, i_cmd_dat};
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
        end
    end

    always_ff @(posedge phy_clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Back-to-back requests stay in REQ so wreq never drops between queued commands.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (!w_empty) w_state_nxt = S_REQ;
            end
            S_REQ: begin
                if (i_mem_ack && (w_count_nxt == '0)) w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge phy_clk or negedge rst) begin
        if (!rst) begin
            r_rsp_valid <= 1'b0;
            r_rsp_we    <= 1'b0;
            r_rsp_dat   <= '0;
        end else begin
            r_rsp_valid <= w_pop;
            if (w_pop) begin
                r_rsp_we <= w_head[EW-1];
                if (!w_head[EW-1]) r_rsp_dat <= i_mem_din;
            end
        end
    end

    // Wide increment so a saturated counter can never re-match the timeout and re-set starve.
    assign w_cnt_inc    = {1'b0, r_stall_cnt} + 9'd1;
    assign w_starve_set = (r_state == S_REQ) & ~i_mem_ack & (w_cnt_inc == 9'(TMO_CYC));

    always_ff @(posedge phy_clk or negedge rst) begin
        if (!rst) begin
            r_stall_cnt <= '0;
            r_starve    <= 1'b0;
        end else begin
            if ((r_state != S_REQ) || i_mem_ack) begin
                r_stall_cnt <= '0;
            end else if (r_stall_cnt != 8'hFF) begin
                r_stall_cnt <= r_stall_cnt + 8'd1;
            end
            if (w_starve_set) begin
                r_starve <= 1'b1;
            end else if (i_starve_clr) begin
                r_starve <= 1'b0;
            end
        end
    end

    assign o_cmd_ready = ~w_full;
    assign o_rsp_valid = r_rsp_valid;
    assign o_rsp_we    = r_rsp_we;
    assign o_rsp_dat   = r_rsp_dat;
    assign o_mem_we    = w_head[EW-1];
    assign o_mem_adr   = w_head[EW-2 -: ADR_W];
    assign o_mem_dout  = w_head[31:0];
    assign o_mem_req   = (r_state == S_REQ);
    assign o_starve    = r_starve;
    assign o_busy      = ~w_empty | (r_state == S_REQ);
    assign o_dbg_state = (r_state == S_REQ);

endmodule

// File: tb/tb_usbf_wb_mem_req.sv
// Bench for usbf_wb_mem_req: a queue-level model of accepted commands, requests and
// completions checked every cycle, plus directed vectors with literal expectations.
module tb_usbf_wb_mem_req;

    localparam int SSRAM_HADR = 14;
    localparam int FIFO_AW    = 1;
    localparam int TMO_CYC    = 255;
    localparam int DEPTH      = 1 << FIFO_AW;
    localparam int ADR_W      = SSRAM_HADR + 1;
    localparam int EW         = 1 + ADR_W + 32;

    logic               phy_clk = 1'b0;
    logic               rst = 1'b1;
    logic               i_cmd_valid = 1'b0;
    logic               o_cmd_ready;
    logic               i_cmd_we = 1'b0;
    logic [ADR_W-1:0]   i_cmd_adr = '0;
    logic [31:0]        i_cmd_dat = '0;
    logic               o_rsp_valid;
    logic               o_rsp_we;
    logic [31:0]        o_rsp_dat;
    logic [ADR_W-1:0]   o_mem_adr;
    logic [31:0]        o_mem_dout;
    logic [31:0]        i_mem_din = '0;
    logic               o_mem_we;
    logic               o_mem_req;
    logic               i_mem_ack = 1'b0;
    logic               o_starve;
    logic               i_starve_clr = 1'b0;
    logic               o_busy;
    logic               o_dbg_state;

    int n_vec = 0;
    int n_err = 0;
    logic run_cmp = 1'b0;

    usbf_wb_mem_req #(
        .SSRAM_HADR(SSRAM_HADR),
        .FIFO_AW   (FIFO_AW),
        .TMO_CYC   (TMO_CYC)
    ) dut (
        .phy_clk     (phy_clk),
        .rst         (rst),
        .i_cmd_valid (i_cmd_valid),
        .o_cmd_ready (o_cmd_ready),
        .i_cmd_we    (i_cmd_we),
        .i_cmd_adr   (i_cmd_adr),
        .i_cmd_dat   (i_cmd_dat),
        .o_rsp_valid (o_rsp_valid),
        .o_rsp_we    (o_rsp_we),
        .o_rsp_dat   (o_rsp_dat),
        .o_mem_adr   (o_mem_adr),
        .o_mem_dout  (o_mem_dout),
        .i_mem_din   (i_mem_din),
        .o_mem_we    (o_mem_we),
        .o_mem_req   (o_mem_req),
        .i_mem_ack   (i_mem_ack),
        .o_starve    (o_starve),
        .i_starve_clr(i_starve_clr),
        .o_busy      (o_busy),
        .o_dbg_state (o_dbg_state)
    );

    // Clock / timeout
    always #5 phy_clk = ~phy_clk;

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, vectors=%0d", n_vec);
        $fatal(1, "timeout");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: exp_q holds accepted commands in order; the head is the
    // outstanding request. Updated on each rising edge from the sampled inputs.
    logic [EW-1:0] exp_q[$];
    logic          m_req;
    logic          m_rsp_valid;
    logic          m_rsp_we;
    logic [31:0]   m_rsp_dat;
    logic          m_starve;
    int            m_stall;
    int            m_old_n;
    logic          m_acc;
    logic          m_ack;
    logic          m_set;
    logic [EW-1:0] m_head;

    always @(posedge phy_clk or negedge rst) begin
        if (!rst) begin
            exp_q.delete();
            m_req       = 1'b0;
            m_rsp_valid = 1'b0;
            m_rsp_we    = 1'b0;
            m_rsp_dat   = '0;
            m_starve    = 1'b0;
            m_stall     = 0;
        end else begin
            m_old_n     = exp_q.size();
            m_acc       = i_cmd_valid && (m_old_n < DEPTH);
            m_ack       = m_req && i_mem_ack;
            m_rsp_valid = 1'b0;
            if (m_ack) begin
                m_head      = exp_q.pop_front();
                m_rsp_valid = 1'b1;
                m_rsp_we    = m_head[EW-1];
                if (!m_head[EW-1]) m_rsp_dat = i_mem_din;
            end
            if (m_acc) exp_q.push_back({i_cmd_we, i_cmd_adr, i_cmd_dat});
            m_set = 1'b0;
            if (m_req && !m_ack) begin
                m_stall++;
                if (m_stall == TMO_CYC) m_set = 1'b1;
            end else begin
                m_stall = 0;
            end
            if (m_set) m_starve = 1'b1;
            else if (i_starve_clr) m_starve = 1'b0;
            if (m_req) m_req = m_ack ? (exp_q.size() != 0) : 1'b1;
            else       m_req = (m_old_n != 0);
        end
    end

    // Scoreboard compare, away from the active edge
    always @(negedge phy_clk) begin
        if (rst && run_cmp) begin
            check("cmd_ready", 64'(o_cmd_ready), 64'(exp_q.size() < DEPTH));
            check("mem_req",   64'(o_mem_req),   64'(m_req));
            check("dbg_state", 64'(o_dbg_state), 64'(m_req));
            check("busy",      64'(o_busy),      64'((exp_q.size() != 0) || m_req));
            check("rsp_valid", 64'(o_rsp_valid), 64'(m_rsp_valid));
            check("rsp_we",    64'(o_rsp_we),    64'(m_rsp_we));
            check("rsp_dat",   64'(o_rsp_dat),   64'(m_rsp_dat));
            check("starve",    64'(o_starve),    64'(m_starve));
            if (exp_q.size() != 0) begin
                check("mem_we",   64'(o_mem_we),   64'(exp_q[0][EW-1]));
                check("mem_adr",  64'(o_mem_adr),  64'(exp_q[0][EW-2 -: ADR_W]));
                check("mem_dout", 64'(o_mem_dout), 64'(exp_q[0][31:0]));
            end
        end
    end

    // Driver tasks
    task automatic tick();
        @(posedge phy_clk);
        #1;
    endtask

    task automatic push(input logic we, input logic [ADR_W-1:0] adr, input logic [31:0] dat);
        int   b;
        logic rdy;
        i_cmd_valid = 1'b1;
        i_cmd_we    = we;
        i_cmd_adr   = adr;
        i_cmd_dat   = dat;
        b = 0;
        do begin
            rdy = o_cmd_ready;
            tick();
            b++;
        end while (!rdy && b < 100);
        if (!rdy) check("push_timeout", 64'(0), 64'(1));
        i_cmd_valid = 1'b0;
    endtask

    task automatic wait_req();
        int b;
        b = 0;
        while (!o_mem_req && b < 50) begin
            tick();
            b++;
        end
        if (!o_mem_req) check("req_timeout", 64'(0), 64'(1));
    endtask

    task automatic ack_one(input int stall, input logic [31:0] din);
        wait_req();
        repeat (stall) tick();
        i_mem_ack = 1'b1;
        i_mem_din = din;
        tick();
        i_mem_ack = 1'b0;
    endtask

    initial begin
        #1 rst = 1'b0;
        #1;
        check("rst_cmd_ready", 64'(o_cmd_ready), 64'(1));
        check("rst_rsp_valid", 64'(o_rsp_valid), 64'(0));
        check("rst_rsp_we",    64'(o_rsp_we),    64'(0));
        check("rst_rsp_dat",   64'(o_rsp_dat),   64'(0));
        check("rst_mem_req",   64'(o_mem_req),   64'(0));
        check("rst_mem_we",    64'(o_mem_we),    64'(0));
        check("rst_mem_adr",   64'(o_mem_adr),   64'(0));
        check("rst_mem_dout",  64'(o_mem_dout),  64'(0));
        check("rst_starve",    64'(o_starve),    64'(0));
        check("rst_busy",      64'(o_busy),      64'(0));
        tick();
        tick();
        rst = 1'b1;
        run_cmp = 1'b1;
        tick();

        // Single write, ack in the first REQ cycle
        push(1'b1, 15'h0010, 32'hDEADBEEF);
        check("wr_req_latency", 64'(o_mem_req), 64'(0));
        check("wr_busy",        64'(o_busy),    64'(1));
        wait_req();
        check("wr_mem_we",  64'(o_mem_we),   64'(1));
        check("wr_mem_adr", 64'(o_mem_adr),  64'(16'h0010));
        check("wr_mem_dat", 64'(o_mem_dout), 64'(32'hDEADBEEF));
        ack_one(0, 32'h0);
        check("wr_rsp_valid", 64'(o_rsp_valid), 64'(1));
        check("wr_rsp_we",    64'(o_rsp_we),    64'(1));
        check("wr_req_drop",  64'(o_mem_req),   64'(0));
        tick();

        // Single read
        push(1'b0, 15'h0010, 32'h0);
        ack_one(0, 32'hDEADBEEF);
        check("rd_rsp_valid", 64'(o_rsp_valid), 64'(1));
        check("rd_rsp_we",    64'(o_rsp_we),    64'(0));
        check("rd_rsp_dat",   64'(o_rsp_dat),   64'(32'hDEADBEEF));
        tick();
        check("rd_rsp_pulse", 64'(o_rsp_valid), 64'(0));
        check("rd_rsp_hold",  64'(o_rsp_dat),   64'(32'hDEADBEEF));

        // Three commands against a two-entry FIFO, ack withheld then back-to-back
        fork
            begin
                push(1'b0, 15'h0020, 32'h0);
                push(1'b1, 15'h0021, 32'h11112222);
                check("full_ready", 64'(o_cmd_ready), 64'(0));
                push(1'b0, 15'h0022, 32'h0);
            end
            begin
                ack_one(3, 32'hA5A50001);
                ack_one(0, 32'h0000FFFF);
                ack_one(0, 32'h12345678);
            end
        join
        check("b2b_rsp_dat", 64'(o_rsp_dat),   64'(32'h12345678));
        check("b2b_rsp_we",  64'(o_rsp_we),    64'(0));
        check("b2b_idle",    64'(o_mem_req),   64'(0));
        tick();

        // Push and pop in the same cycle with one entry queued
        push(1'b1, 15'h0030, 32'hAAAA0030);
        wait_req();
        i_mem_ack   = 1'b1;
        i_mem_din   = 32'h0;
        i_cmd_valid = 1'b1;
        i_cmd_we    = 1'b0;
        i_cmd_adr   = 15'h0031;
        i_cmd_dat   = 32'h0;
        tick();
        i_mem_ack   = 1'b0;
        i_cmd_valid = 1'b0;
        check("pp_req",     64'(o_mem_req),   64'(1));
        check("pp_head",    64'(o_mem_adr),   64'(16'h0031));
        check("pp_head_we", 64'(o_mem_we),    64'(0));
        check("pp_ready",   64'(o_cmd_ready), 64'(1));
        check("pp_rsp_we",  64'(o_rsp_we),    64'(1));
        ack_one(0, 32'hCAFE0031);
        check("pp_rsp_dat", 64'(o_rsp_dat),   64'(32'hCAFE0031));
        tick();

        // Starvation: 300 cycles without ack
        push(1'b1, 15'h0040, 32'h40404040);
        wait_req();
        repeat (254) tick();
        check("starve_early", 64'(o_starve), 64'(0));
        tick();
        check("starve_set",   64'(o_starve),  64'(1));
        check("starve_req",   64'(o_mem_req), 64'(1));
        repeat (45) tick();
        ack_one(0, 32'h0);
        check("starve_ack_rsp", 64'(o_rsp_valid), 64'(1));
        check("starve_sticky",  64'(o_starve),    64'(1));
        i_starve_clr = 1'b1;
        tick();
        i_starve_clr = 1'b0;
        check("starve_clr", 64'(o_starve), 64'(0));
        tick();

        // Reset while in REQ with two queued
        push(1'b0, 15'h0050, 32'h0);
        push(1'b1, 15'h0051, 32'h51515151);
        check("prerst_req", 64'(o_mem_req), 64'(1));
        #2 rst = 1'b0;
        #1;
        check("arst_req",   64'(o_mem_req),   64'(0));
        check("arst_busy",  64'(o_busy),      64'(0));
        check("arst_ready", 64'(o_cmd_ready), 64'(1));
        tick();
        tick();
        rst = 1'b1;
        repeat (5) tick();
        check("postrst_rsp", 64'(o_rsp_valid), 64'(0));
        check("postrst_req", 64'(o_mem_req),   64'(0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
